// File: rtl/ice_rail_sequencer.sv
// iCE rail power sequencer: ramp, settle, ready, with bounded retries and a sticky fault.
// Optional rail_pgood 4-sample filter enabled by defining SEQ_PGOOD_FILTER_EN.
module ice_rail_sequencer #(
    parameter int unsigned SETTLE_CYCLES  = 64,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_W          = 11,
    parameter int unsigned RETRY_MAX      = 3
) (
    input  logic       sclk,
    input  logic       n_ice_reset,
    input  logic       ice_power,
    input  logic       main_en,
    input  logic       rail_pgood,
    output logic       ice_rail_en,
    output logic       seq_ready,
    output logic       seq_fault,
    output logic [1:0] retry_cnt,
    output logic [2:0] seq_state
);

    typedef enum logic [2:0] {
        S_OFF     = 3'd0,
        S_RAMP    = 3'd1,
        S_SETTLE  = 3'd2,
        S_READY   = 3'd3,
        S_BACKOFF = 3'd4,
        S_FAULT   = 3'd5
    } state_e;

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [1:0]       RETRY_LIM    = 2'(RETRY_MAX);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       retry_q, retry_d, retry_sat;
    logic             rail_en_q, rail_en_d;
    logic             ready_q, ready_d;
    logic             fault_q, fault_d;
    logic             pgood;

`ifdef SEQ_PGOOD_FILTER_EN
    logic [3:0] pg_hist_q, pg_hist_d;
    logic       pg_filt_q, pg_filt_d;

    // Filtered level only flips once the last four samples (including this one) agree.
    always_comb begin
        pg_hist_d = {pg_hist_q[2:0], rail_pgood};
        pg_filt_d = pg_filt_q;
        if (&pg_hist_d)
            pg_filt_d = 1'b1;
        else if (~|pg_hist_d)
            pg_filt_d = 1'b0;
    end

    always_ff @(posedge sclk or posedge n_ice_reset) begin
        if (n_ice_reset) begin
            pg_hist_q <= '0;
            pg_filt_q <= 1'b0;
        end else begin
            pg_hist_q <= pg_hist_d;
            pg_filt_q <= pg_filt_d;
        end
    end

    assign pgood = pg_filt_q;
`else
    assign pgood = rail_pgood;
`endif

    assign retry_sat = (retry_q == RETRY_LIM) ? retry_q : retry_q + 2'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;

        // Losing the request or the main rail drops every active state to OFF without a retry.
        if ((state_q inside {S_RAMP, S_SETTLE, S_READY, S_BACKOFF}) && !(ice_power && main_en)) begin
            state_d = S_OFF;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_OFF: begin
                    if (ice_power && main_en) begin
                        state_d = S_RAMP;
                        cnt_d   = '0;
                    end
                end
                S_RAMP: begin
                    if (pgood) begin
                        state_d = S_SETTLE;
                        cnt_d   = '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        state_d = S_BACKOFF;
                        retry_d = retry_sat;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_SETTLE: begin
                    if (!pgood) begin
                        state_d = S_BACKOFF;
                        retry_d = retry_sat;
                        cnt_d   = '0;
                    end else if (cnt_q == SETTLE_LAST) begin
                        state_d = S_READY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_READY: begin
                    if (!pgood) begin
                        state_d = S_BACKOFF;
                        retry_d = retry_sat;
                        cnt_d   = '0;
                    end
                end
                S_BACKOFF: begin
                    if (cnt_q == SETTLE_LAST) begin
                        state_d = (retry_q == RETRY_LIM) ? S_FAULT : S_OFF;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_FAULT: begin
                end
                default: begin
                    state_d = S_OFF;
                    cnt_d   = '0;
                end
            endcase
        end

        // Outputs are decoded from the next state so the flops track the state register.
        rail_en_d = (state_d == S_RAMP) || (state_d == S_SETTLE) || (state_d == S_READY);
        ready_d   = (state_d == S_READY);
        fault_d   = (state_d == S_FAULT);
    end

    always_ff @(posedge sclk or posedge n_ice_reset) begin
        if (n_ice_reset) begin
            state_q   <= S_OFF;
            cnt_q     <= '0;
            retry_q   <= '0;
            rail_en_q <= 1'b0;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            rail_en_q <= rail_en_d;
            ready_q   <= ready_d;
            fault_q   <= fault_d;
        end
    end

    assign ice_rail_en = rail_en_q;
    assign seq_ready   = ready_q;
    assign seq_fault   = fault_q;
    assign retry_cnt   = retry_q;
    assign seq_state   = state_q;

endmodule

// File: tb/tb_ice_rail_sequencer.sv
// Directed bench for ice_rail_sequencer (default build, unfiltered rail_pgood).
module tb_ice_rail_sequencer;

    logic       sclk        = 1'b0;
    logic       n_ice_reset = 1'b1;
    logic       ice_power   = 1'b0;
    logic       main_en     = 1'b0;
    logic       rail_pgood  = 1'b0;
    logic       ice_rail_en;
    logic       seq_ready;
    logic       seq_fault;
    logic [1:0] retry_cnt;
    logic [2:0] seq_state;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 sclk = ~sclk;

    ice_rail_sequencer #(
        .SETTLE_CYCLES (64),
        .TIMEOUT_CYCLES(1024),
        .CNT_W         (11),
        .RETRY_MAX     (3)
    ) dut (
        .sclk       (sclk),
        .n_ice_reset(n_ice_reset),
        .ice_power  (ice_power),
        .main_en    (main_en),
        .rail_pgood (rail_pgood),
        .ice_rail_en(ice_rail_en),
        .seq_ready  (seq_ready),
        .seq_fault  (seq_fault),
        .retry_cnt  (retry_cnt),
        .seq_state  (seq_state)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge sclk);
    endtask

    task automatic apply_reset();
        n_ice_reset = 1'b1;
        step(2);
        n_ice_reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        step(2);
        check("rst_en",    int'(ice_rail_en), 0);
        check("rst_ready", int'(seq_ready),   0);
        check("rst_fault", int'(seq_fault),   0);
        check("rst_retry", int'(retry_cnt),   0);
        check("rst_state", int'(seq_state),   0);

        // Nominal bring-up
        n_ice_reset = 1'b0;
        ice_power   = 1'b1;
        main_en     = 1'b1;
        step(1);
        check("up_en",    int'(ice_rail_en), 1);
        check("up_ramp",  int'(seq_state),   1);
        step(9);
        rail_pgood = 1'b1;
        step(1);
        check("up_settle", int'(seq_state), 2);
        step(63);
        check("up_ready_early", int'(seq_ready), 0);
        check("up_settle_last", int'(seq_state), 2);
        step(1);
        check("up_ready", int'(seq_ready),   1);
        check("up_st3",   int'(seq_state),   3);
        check("up_retry", int'(retry_cnt),   0);
        check("up_en_hi", int'(ice_rail_en), 1);

        // Brownout: one-cycle pgood drop in READY
        rail_pgood = 1'b0;
        step(1);
        rail_pgood = 1'b1;
        check("bo_ready", int'(seq_ready),   0);
        check("bo_state", int'(seq_state),   4);
        check("bo_retry", int'(retry_cnt),   1);
        check("bo_en",    int'(ice_rail_en), 0);
        step(63);
        check("bo_hold", int'(seq_state), 4);
        step(1);
        check("bo_off", int'(seq_state), 0);
        step(1);
        check("bo_reramp", int'(seq_state),   1);
        check("bo_re_en",  int'(ice_rail_en), 1);
        step(1);
        check("bo_resettle", int'(seq_state), 2);
        step(64);
        check("bo_reready", int'(seq_state), 3);

        // main_en drop in READY
        main_en = 1'b0;
        step(1);
        check("men_off",   int'(seq_state),   0);
        check("men_en",    int'(ice_rail_en), 0);
        check("men_retry", int'(retry_cnt),   1);

        // ice_power drop mid-SETTLE at count 30
        main_en = 1'b1;
        step(1);
        check("pd_ramp", int'(seq_state), 1);
        step(1);
        check("pd_settle", int'(seq_state), 2);
        step(30);
        check("pd_settle30", int'(seq_state), 2);
        ice_power = 1'b0;
        step(1);
        check("pd_off",   int'(seq_state),   0);
        check("pd_en",    int'(ice_rail_en), 0);
        check("pd_retry", int'(retry_cnt),   1);

        // Second brownout to reach READY with retry_cnt=2
        ice_power = 1'b1;
        step(2);
        step(64);
        check("b2_ready", int'(seq_state), 3);
        rail_pgood = 1'b0;
        step(1);
        rail_pgood = 1'b1;
        check("b2_retry", int'(retry_cnt), 2);
        step(64);
        check("b2_off", int'(seq_state), 0);
        step(2);
        step(64);
        check("b2_reready", int'(seq_state), 3);
        check("b2_retry_kept", int'(retry_cnt), 2);

        // Asynchronous reset between clock edges
        #2;
        n_ice_reset = 1'b1;
        #1;
        check("ar_en",    int'(ice_rail_en), 0);
        check("ar_ready", int'(seq_ready),   0);
        check("ar_fault", int'(seq_fault),   0);
        check("ar_retry", int'(retry_cnt),   0);
        check("ar_state", int'(seq_state),   0);
        step(2);
        n_ice_reset = 1'b0;
        step(1);
        check("ar_ramp", int'(seq_state), 1);
        step(1);
        check("ar_settle", int'(seq_state), 2);
        step(64);
        check("ar_ready2", int'(seq_ready), 1);
        check("ar_retry2", int'(retry_cnt), 0);

        // Ramp timeout with retries to FAULT
        rail_pgood = 1'b0;
        apply_reset();
        step(1);
        for (int a = 1; a <= 3; a++) begin
            check("to_ramp", int'(seq_state),   1);
            check("to_en",   int'(ice_rail_en), 1);
            step(1023);
            check("to_en_last", int'(ice_rail_en), 1);
            step(1);
            check("to_en_lo",  int'(ice_rail_en), 0);
            check("to_backoff", int'(seq_state),  4);
            check("to_retry",  int'(retry_cnt),   a);
            step(63);
            check("to_bo_last", int'(seq_state), 4);
            step(1);
            if (a < 3) begin
                check("to_off", int'(seq_state), 0);
                step(1);
            end else begin
                check("to_fault_st", int'(seq_state),   5);
                check("to_fault",    int'(seq_fault),   1);
                check("to_fault_en", int'(ice_rail_en), 0);
            end
        end
        rail_pgood = 1'b1;
        step(20);
        check("ft_state", int'(seq_state),   5);
        check("ft_en",    int'(ice_rail_en), 0);
        check("ft_fault", int'(seq_fault),   1);
        check("ft_retry", int'(retry_cnt),   3);

        // pgood rising on the RAMP timeout cycle, then falling on the terminal SETTLE cycle
        rail_pgood = 1'b0;
        apply_reset();
        step(1);
        check("rc_ramp", int'(seq_state), 1);
        step(1023);
        rail_pgood = 1'b1;
        step(1);
        check("rc_settle", int'(seq_state), 2);
        check("rc_retry",  int'(retry_cnt), 0);
        step(63);
        check("rc_settle_last", int'(seq_state), 2);
        rail_pgood = 1'b0;
        step(1);
        check("rc_backoff", int'(seq_state), 4);
        check("rc_retry1",  int'(retry_cnt), 1);
        check("rc_ready",   int'(seq_ready), 0);

        // Three-cycle pgood glitch in RAMP (unfiltered)
        rail_pgood = 1'b0;
        apply_reset();
        step(1);
        check("gl_ramp", int'(seq_state), 1);
        rail_pgood = 1'b1;
        step(1);
        check("gl_settle", int'(seq_state), 2);
        step(2);
        rail_pgood = 1'b0;
        step(1);
        check("gl_backoff", int'(seq_state), 4);
        check("gl_retry",   int'(retry_cnt), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
